// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file access arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which requester holds the register-file port
//   own_state() : maps an owner onto its OWN_x state
package rf_arb_pkg;

  localparam int unsigned DefAddrW     = 8;
  localparam int unsigned DefDataW     = 32;
  localparam int unsigned DefRdTimeout = 16;

  typedef enum logic [2:0] {
    StIdle,
    StOwnS,
    StOwnL,
    StDeferRd,  // write issued, read of the same command pair still to go
    StRdWait
  } arb_state_e;

  // Encoding is relied on by the tracker's 1-bit owner tag.
  typedef enum logic {
    OwnSlave = 1'b0,
    OwnLocal = 1'b1
  } owner_e;

  function automatic arb_state_e own_state(owner_e owner);
    return (owner == OwnLocal) ? StOwnL : StOwnS;
  endfunction

endpackage

// File: rtl/rf_arb_rd_tracker.sv
// Read-completion tracker for rf_access_arbiter.
//   clk_i, reset_i : clock, synchronous active-high reset
//   capture_i      : a read was accepted; latch owner_i as the read's owner
//   owner_i        : owner of the accepted read (rf_arb_pkg::owner_e encoding)
//   load_i         : arbiter enters RD_WAIT; counter restarts at 1
//   active_i       : arbiter is in RD_WAIT
//   rd_valid_i     : register_file read-data valid
//   owner_o        : owner tag of the outstanding read
//   done_o         : read data arrived this cycle
//   timeout_o      : wait budget exhausted without data this cycle
module rf_arb_rd_tracker
  import rf_arb_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = DefRdTimeout
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic capture_i,
  input  logic owner_i,
  input  logic load_i,
  input  logic active_i,
  input  logic rd_valid_i,
  output logic owner_o,
  output logic done_o,
  output logic timeout_o
);

  localparam int unsigned CntW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(RD_TIMEOUT);

  logic [CntW-1:0] cnt_q;
  logic            owner_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      owner_q <= OwnSlave;
    end else begin
      if (capture_i) begin
        owner_q <= owner_i;
      end
      // Counter value equals the index of the current RD_WAIT cycle.
      if (load_i) begin
        cnt_q <= CntW'(1);
      end else if (active_i && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Data arriving on the last allowed cycle still counts as a real completion.
  assign done_o    = active_i & rd_valid_i;
  assign timeout_o = active_i & ~rd_valid_i & (cnt_q == CntMax);
  assign owner_o   = owner_q;

endmodule

// File: rtl/rf_access_arbiter.sv
// Single-port owner/responder for register_file.
// Arbitrates between the AXI-lite slave rf* port and a local control port,
// round-robin on ties, drives register_file rd/wr, and routes read data back
// to the requester that issued the read.
//   clk, reset                : clock, synchronous active-high reset
//   slave_need_rf, rf*        : slave ownership request / commands / read return
//   loc_*                     : local ownership request / commands / read return
//   rf_busy, loc_busy         : that side's commands are ignored this cycle
//   wr_en/wr_addr/wr_data     : register_file write port (registered)
//   rd_en/rd_addr             : register_file read port (registered)
//   rd_data, rf_rd_valid      : register_file read return
//   rd_timeout                : pulses with the strobe of a forced read completion
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned RD_TIMEOUT = DefRdTimeout
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slave_need_rf,
  input  logic              rfwrcmd,
  input  logic              rfrdcmd,
  input  logic [ADDR_W-1:0] rfwraddr,
  input  logic [ADDR_W-1:0] rfrdaddr,
  input  logic [DATA_W-1:0] rfwrdata,
  output logic [DATA_W-1:0] rfrddata,
  output logic              rf_busy,
  output logic              rf_data_valid,
  input  logic              loc_req,
  input  logic              loc_wrcmd,
  input  logic              loc_rdcmd,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wrdata,
  output logic [DATA_W-1:0] loc_rddata,
  output logic              loc_busy,
  output logic              loc_data_valid,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rf_rd_valid,
  output logic              rd_timeout
);

  arb_state_e        state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] rf_rddata_q, rf_rddata_d;
  logic [DATA_W-1:0] loc_rddata_q, loc_rddata_d;
  logic              rf_dv_q, rf_dv_d;
  logic              loc_dv_q, loc_dv_d;
  logic              tmo_q, tmo_d;

  // Command view of whichever side currently owns the port.
  logic              own_loc;
  logic              own_req, own_wr, own_rd;
  logic [ADDR_W-1:0] own_wraddr, own_rdaddr;
  logic [DATA_W-1:0] own_wrdata;

  assign own_loc    = (state_q == StOwnL);
  assign own_req    = own_loc ? loc_req    : slave_need_rf;
  assign own_wr     = own_loc ? loc_wrcmd  : rfwrcmd;
  assign own_rd     = own_loc ? loc_rdcmd  : rfrdcmd;
  assign own_wraddr = own_loc ? loc_addr   : rfwraddr;
  assign own_rdaddr = own_loc ? loc_addr   : rfrdaddr;
  assign own_wrdata = own_loc ? loc_wrdata : rfwrdata;

  logic   trk_capture, trk_load, trk_active;
  logic   trk_owner, trk_done, trk_tmo;
  owner_e rd_owner;
  logic   rd_owner_req;

  assign trk_active   = (state_q == StRdWait);
  assign rd_owner     = owner_e'(trk_owner);
  assign rd_owner_req = (rd_owner == OwnLocal) ? loc_req : slave_need_rf;

  rf_arb_rd_tracker #(
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_rd_tracker (
    .clk_i      (clk),
    .reset_i    (reset),
    .capture_i  (trk_capture),
    .owner_i    (own_loc),
    .load_i     (trk_load),
    .active_i   (trk_active),
    .rd_valid_i (rf_rd_valid),
    .owner_o    (trk_owner),
    .done_o     (trk_done),
    .timeout_o  (trk_tmo)
  );

  always_comb begin
    owner_e            grant;
    logic [DATA_W-1:0] ret_data;

    state_d      = state_q;
    last_owner_d = last_owner_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_addr_d    = rd_addr_q;
    pend_addr_d  = pend_addr_q;
    rf_rddata_d  = rf_rddata_q;
    loc_rddata_d = loc_rddata_q;
    rf_dv_d      = 1'b0;
    loc_dv_d     = 1'b0;
    tmo_d        = 1'b0;
    trk_capture  = 1'b0;
    trk_load     = 1'b0;
    grant        = OwnSlave;
    ret_data     = trk_done ? rd_data : '0;

    unique case (state_q)
      StIdle: begin
        // Commands are never looked at here; only ownership is decided.
        if (slave_need_rf || loc_req) begin
          if (slave_need_rf && loc_req) begin
            grant = (last_owner_q == OwnLocal) ? OwnSlave : OwnLocal;
          end else begin
            grant = loc_req ? OwnLocal : OwnSlave;
          end
          state_d      = own_state(grant);
          last_owner_d = grant;
        end
      end

      StOwnS, StOwnL: begin
        if (!own_req) begin
          state_d = StIdle;
        end else begin
          if (own_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = own_wraddr;
            wr_data_d = own_wrdata;
          end
          if (own_rd) begin
            trk_capture = 1'b1;
            if (own_wr) begin
              // Read goes out one cycle after the write so it sees the new value.
              pend_addr_d = own_rdaddr;
              state_d     = StDeferRd;
            end else begin
              rd_en_d   = 1'b1;
              rd_addr_d = own_rdaddr;
              trk_load  = 1'b1;
              state_d   = StRdWait;
            end
          end
        end
      end

      StDeferRd: begin
        rd_en_d   = 1'b1;
        rd_addr_d = pend_addr_q;
        trk_load  = 1'b1;
        state_d   = StRdWait;
      end

      StRdWait: begin
        if (trk_done || trk_tmo) begin
          if (rd_owner == OwnLocal) begin
            loc_rddata_d = ret_data;
            loc_dv_d     = 1'b1;
          end else begin
            rf_rddata_d = ret_data;
            rf_dv_d     = 1'b1;
          end
          tmo_d   = trk_tmo;
          state_d = rd_owner_req ? own_state(rd_owner) : StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_owner_q <= OwnLocal;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pend_addr_q  <= '0;
      wr_data_q    <= '0;
      rf_rddata_q  <= '0;
      loc_rddata_q <= '0;
      rf_dv_q      <= 1'b0;
      loc_dv_q     <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      pend_addr_q  <= pend_addr_d;
      wr_data_q    <= wr_data_d;
      rf_rddata_q  <= rf_rddata_d;
      loc_rddata_q <= loc_rddata_d;
      rf_dv_q      <= rf_dv_d;
      loc_dv_q     <= loc_dv_d;
      tmo_q        <= tmo_d;
    end
  end

  assign rf_busy        = (state_q != StOwnS);
  assign loc_busy       = (state_q != StOwnL);
  assign wr_en          = wr_en_q;
  assign rd_en          = rd_en_q;
  assign wr_addr        = wr_addr_q;
  assign rd_addr        = rd_addr_q;
  assign wr_data        = wr_data_q;
  assign rfrddata       = rf_rddata_q;
  assign loc_rddata     = loc_rddata_q;
  assign rf_data_valid  = rf_dv_q;
  assign loc_data_valid = loc_dv_q;
  assign rd_timeout     = tmo_q;

endmodule
